pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port stallD, input, 1, load-use hazard reported for the D-stage instruction.
REQ-004 SHALL have port cannot_predictD, input, 1, D-stage branch/jalr target or condition not computable.
REQ-005 SHALL have port jump_codeD, input, 2, D-stage control type: 00 none, 01 branch, 10 jal, 11 jalr.
REQ-006 SHALL have ports pred_takenD (input, 1) and pred_targetD (input, 32): D-stage decided redirect.
REQ-007 SHALL have ports resolve_validE (input, 1), resolve_takenE (input, 1) and resolve_targetE (input, 32): E-stage resolution of the speculated instruction.
REQ-008 SHALL have outputs pc_en, ifid_en, ifid_flush, idex_bubble, each 1 bit: pipeline register controls.
REQ-009 SHALL have outputs pc_sel (2; 00 +4, 01 D target, 10 E target) and next_target (32): PC mux control and selected redirect address.
REQ-010 SHALL have output spec_tagD, 1: marks the D instruction entering E as speculative.
REQ-011 SHALL have outputs stall_cnt (16), flush_cnt (16) and spec_err (1).

Function
REQ-012 SHALL implement FSM states RUN and SPEC; outputs are combinational from state and inputs.
REQ-013 Default outputs SHALL be: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, pc_sel=00, next_target=0, spec_tagD=0.
REQ-014 SPEC with resolve_validE=1 and resolve_takenE=1 SHALL drive pc_sel=10, next_target=resolve_targetE, ifid_flush=1 and idex_bubble=1, and go to RUN; this has highest priority and suppresses all D-stage actions.
REQ-015 SPEC with resolve_validE=1 and resolve_takenE=0 SHALL go to RUN and apply the RUN rules to the D inputs in the same cycle.
REQ-016 SPEC with resolve_validE=0 SHALL hold SPEC, drive default outputs, ignore D-stage redirects, and increment the 2-bit spec_age.
REQ-017 SHALL set spec_err (sticky) when spec_age reaches 2, and then force the state to RUN.
REQ-018 RUN with stallD=1 SHALL drive pc_en=0, ifid_en=0 and idex_bubble=1; stallD SHALL take priority over all D-stage redirects.
REQ-019 RUN with stallD=0, jump_codeD!=00 and cannot_predictD=1 SHALL assert spec_tagD, keep pc_sel=00, clear spec_age and go to SPEC.
REQ-020 RUN with stallD=0, cannot_predictD=0, jump_codeD!=00 and pred_takenD=1 SHALL drive pc_sel=01, next_target=pred_targetD and ifid_flush=1.
REQ-021 cannot_predictD with jump_codeD=00 SHALL be ignored.
REQ-022 stall_cnt SHALL increment on every cycle with idex_bubble=1 caused by stallD, and saturate at 0xFFFF.
REQ-023 flush_cnt SHALL increment on every cycle with ifid_flush=1, and saturate at 0xFFFF.
REQ-024 A cycle that is both a stall bubble and an E flush SHALL count only as a flush.

Reset
REQ-025 reset=1 SHALL force state RUN, spec_age=0, stall_cnt=0, flush_cnt=0 and spec_err=0 at the next edge.
REQ-026 While reset=1, the combinational outputs SHALL take the REQ-013 defaults.
REQ-027 Reset in SPEC SHALL abandon the pending resolution without a flush.

Structure
REQ-028 The jump_code encodings, the pc_sel encodings, the FSM state enum and the spec_age limit (2) SHALL live in the shared pipeline package.
REQ-029 A sub-module sat_counter (parameter width, inc and reset) SHALL be used for both counters.
REQ-030 No further hierarchy SHALL be used.

Verification
REQ-031 Scenario: stallD=1 for 3 cycles in RUN -> pc_en=0 and idex_bubble=1 for 3 cycles; stall_cnt=3.
REQ-032 Scenario: jump_codeD=01, pred_takenD=1, pred_targetD=0x100 -> pc_sel=01, next_target=0x100, ifid_flush=1, flush_cnt=1.
REQ-033 Scenario: jump_codeD=11, cannot_predictD=1 -> spec_tagD=1 and state SPEC; next cycle resolve_validE=1, resolve_takenE=1, resolve_targetE=0x2000 -> pc_sel=10, next_target=0x2000, ifid_flush=1, idex_bubble=1, state RUN.
REQ-034 Scenario: in SPEC, resolve_takenE=0 with D pred_takenD=1 and pred_targetD=0x40 -> pc_sel=01, next_target=0x40.
REQ-035 Scenario: in SPEC, resolve_validE=0 for 2 cycles -> spec_err=1 and state RUN.
REQ-036 Scenario: reset asserted while in SPEC, and 0xFFFF plus 2 stalls -> state RUN with counters 0 after reset; stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline encodings, FSM states and speculation limit
package pipe_ctrl_pkg;
  typedef enum logic {RUN, SPEC} state_t;
  localparam logic [1:0] JC_NONE = 2'b00;
  localparam logic [1:0] JC_BR   = 2'b01;
  localparam logic [1:0] JC_JAL  = 2'b10;
  localparam logic [1:0] JC_JALR = 2'b11;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_D     = 2'b01;
  localparam logic [1:0] PC_E     = 2'b10;
  localparam logic [1:0] SPEC_AGE_LIMIT = 2'd2;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= reset ? '0 : (inc && !(&cnt)) ? cnt + width'(1) : cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/redirect/speculation control for the IF-ID-EX front end
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        cannot_predictD,
  input  logic [1:0]  jump_codeD,
  input  logic        pred_takenD,
  input  logic [31:0] pred_targetD,
  input  logic        resolve_validE,
  input  logic        resolve_takenE,
  input  logic [31:0] resolve_targetE,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  pc_sel,
  output logic [31:0] next_target,
  output logic        spec_tagD,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        spec_err
);
  state_t     state;
  logic [1:0] spec_age;
  logic       resolve, e_flush, run_rules, stall, has_jump, go_spec, d_redir, timeout;
  always_comb begin
    resolve   = state == SPEC && resolve_validE;
    e_flush   = !reset && resolve && resolve_takenE;
    // a not-taken resolution releases SPEC and lets D act in the same cycle
    run_rules = !reset && (state == RUN || (resolve && !resolve_takenE));
    stall     = run_rules && stallD;
    has_jump  = jump_codeD != JC_NONE;
    go_spec   = run_rules && !stallD && has_jump && cannot_predictD;
    d_redir   = run_rules && !stallD && has_jump && !cannot_predictD && pred_takenD;
    timeout   = state == SPEC && !resolve_validE && spec_age + 2'd1 == SPEC_AGE_LIMIT;
    pc_en       = !stall;
    ifid_en     = !stall;
    ifid_flush  = e_flush || d_redir;
    idex_bubble = e_flush || stall;
    pc_sel      = e_flush ? PC_E : d_redir ? PC_D : PC_PLUS4;
    next_target = e_flush ? resolve_targetE : d_redir ? pred_targetD : 32'd0;
    spec_tagD   = go_spec;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      spec_age <= '0;
      spec_err <= 1'b0;
    end else if (e_flush) begin
      state <= RUN;
    end else if (run_rules) begin
      state    <= go_spec ? SPEC : RUN;
      spec_age <= go_spec ? 2'd0 : spec_age;
    end else if (state == SPEC) begin
      state    <= timeout ? RUN : SPEC;
      spec_age <= timeout ? 2'd0 : spec_age + 2'd1;
      spec_err <= spec_err || timeout;
    end
  end
  sat_counter #(.width(16)) u_stall_cnt (.clk(clk), .reset(reset), .inc(stall), .cnt(stall_cnt));
  sat_counter #(.width(16)) u_flush_cnt (.clk(clk), .reset(reset), .inc(ifid_flush), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  logic        clk = 0, reset = 1, stallD, cannot_predictD, pred_takenD, resolve_validE, resolve_takenE;
  logic [1:0]  jump_codeD;
  logic [31:0] pred_targetD, resolve_targetE;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, spec_tagD, spec_err;
  logic [1:0]  pc_sel;
  logic [31:0] next_target;
  logic [15:0] stall_cnt, flush_cnt;
  int n_tests = 0, n_fail = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .stallD(stallD), .cannot_predictD(cannot_predictD),
    .jump_codeD(jump_codeD), .pred_takenD(pred_takenD), .pred_targetD(pred_targetD),
    .resolve_validE(resolve_validE), .resolve_takenE(resolve_takenE), .resolve_targetE(resolve_targetE),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pc_sel(pc_sel), .next_target(next_target), .spec_tagD(spec_tagD),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .spec_err(spec_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stallD = 0; cannot_predictD = 0; jump_codeD = JC_NONE; pred_takenD = 0; pred_targetD = 0;
    resolve_validE = 0; resolve_takenE = 0; resolve_targetE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_spec();
    clr(); jump_codeD = JC_JALR; cannot_predictD = 1;
    tick(); clr(); #1;
    chk("enter_spec_state", 32'(dut.state), 32'(SPEC));
  endtask

  initial begin
    clr();
    stallD = 1; jump_codeD = JC_BR; pred_takenD = 1; pred_targetD = 32'h80;
    resolve_validE = 1; resolve_takenE = 1;
    #1;
    chk("rst_pc_en", 32'(pc_en), 1);
    chk("rst_bubble", 32'(idex_bubble), 0);
    chk("rst_flush", 32'(ifid_flush), 0);
    chk("rst_pc_sel", 32'(pc_sel), 0);
    tick(); tick();
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_spec_err", 32'(spec_err), 0);
    chk("rst_state", 32'(dut.state), 32'(RUN));
    reset = 0; clr();
    stallD = 1; jump_codeD = JC_BR; pred_takenD = 1; pred_targetD = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc_en", 32'(pc_en), 0);
      chk("stall_ifid_en", 32'(ifid_en), 0);
      chk("stall_bubble", 32'(idex_bubble), 1);
      chk("stall_no_redirect", 32'(pc_sel), 0);
      tick();
    end
    clr(); #1;
    chk("stall_cnt3", 32'(stall_cnt), 3);
    chk("unstall_pc_en", 32'(pc_en), 1);
    jump_codeD = JC_BR; pred_takenD = 1; pred_targetD = 32'h100; #1;
    chk("pred_pc_sel", 32'(pc_sel), 32'(PC_D));
    chk("pred_target", next_target, 32'h100);
    chk("pred_flush", 32'(ifid_flush), 1);
    chk("pred_bubble", 32'(idex_bubble), 0);
    tick(); clr(); #1;
    chk("pred_flush_cnt", 32'(flush_cnt), 1);
    chk("pred_state", 32'(dut.state), 32'(RUN));
    jump_codeD = JC_NONE; cannot_predictD = 1; pred_takenD = 1; pred_targetD = 32'h55; #1;
    chk("nojump_tag", 32'(spec_tagD), 0);
    chk("nojump_pc_sel", 32'(pc_sel), 0);
    chk("nojump_flush", 32'(ifid_flush), 0);
    tick();
    chk("nojump_state", 32'(dut.state), 32'(RUN));
    clr(); jump_codeD = JC_JALR; cannot_predictD = 1; #1;
    chk("spec_tag", 32'(spec_tagD), 1);
    chk("spec_pc_sel", 32'(pc_sel), 0);
    chk("spec_flush", 32'(ifid_flush), 0);
    tick(); clr();
    chk("spec_state", 32'(dut.state), 32'(SPEC));
    resolve_validE = 1; resolve_takenE = 1; resolve_targetE = 32'h2000;
    stallD = 1; jump_codeD = JC_BR; pred_takenD = 1; pred_targetD = 32'h40; #1;
    chk("eflush_pc_sel", 32'(pc_sel), 32'(PC_E));
    chk("eflush_target", next_target, 32'h2000);
    chk("eflush_flush", 32'(ifid_flush), 1);
    chk("eflush_bubble", 32'(idex_bubble), 1);
    chk("eflush_pc_en", 32'(pc_en), 1);
    tick(); clr(); #1;
    chk("eflush_state", 32'(dut.state), 32'(RUN));
    chk("eflush_flush_cnt", 32'(flush_cnt), 2);
    chk("eflush_stall_cnt", 32'(stall_cnt), 3);
    enter_spec();
    resolve_validE = 1; resolve_takenE = 0; jump_codeD = JC_BR; pred_takenD = 1; pred_targetD = 32'h40; #1;
    chk("nt_pc_sel", 32'(pc_sel), 32'(PC_D));
    chk("nt_target", next_target, 32'h40);
    chk("nt_flush", 32'(ifid_flush), 1);
    tick(); clr(); #1;
    chk("nt_state", 32'(dut.state), 32'(RUN));
    chk("nt_flush_cnt", 32'(flush_cnt), 3);
    enter_spec();
    stallD = 1; jump_codeD = JC_BR; pred_takenD = 1; pred_targetD = 32'h44; #1;
    chk("wait_pc_sel", 32'(pc_sel), 0);
    chk("wait_pc_en", 32'(pc_en), 1);
    chk("wait_bubble", 32'(idex_bubble), 0);
    tick();
    chk("wait1_state", 32'(dut.state), 32'(SPEC));
    chk("wait1_err", 32'(spec_err), 0);
    tick(); clr(); #1;
    chk("wait2_err", 32'(spec_err), 1);
    chk("wait2_state", 32'(dut.state), 32'(RUN));
    chk("wait_stall_cnt", 32'(stall_cnt), 3);
    tick();
    chk("err_sticky", 32'(spec_err), 1);
    enter_spec();
    reset = 1; resolve_validE = 1; resolve_takenE = 1; resolve_targetE = 32'h3000; #1;
    chk("rspec_flush", 32'(ifid_flush), 0);
    chk("rspec_pc_sel", 32'(pc_sel), 0);
    chk("rspec_target", next_target, 0);
    tick(); clr(); #1;
    chk("rspec_state", 32'(dut.state), 32'(RUN));
    chk("rspec_stall_cnt", 32'(stall_cnt), 0);
    chk("rspec_flush_cnt", 32'(flush_cnt), 0);
    chk("rspec_err", 32'(spec_err), 0);
    reset = 0; stallD = 1;
    for (int i = 0; i < 32'h10001; i++) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat_bubble", 32'(idex_bubble), 1);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat_flush_cnt", 32'(flush_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
